// File: rtl/stoch_mmult_sequencer_pkg.sv
// Shared definitions for the stochastic matrix-multiply run sequencer:
// FSM state encoding and the accumulator/count width helper.
package stoch_mmult_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StFlush = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } seq_state_e;

    // One extra bit so a full window of ones (2^CNT_WIDTH) fits without overflow.
    function automatic int unsigned count_width(input int unsigned cnt_width);
        return cnt_width + 1;
    endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Ones counter for a single product bitstream; synchronous clear wins over enable.
module stoch_ones_counter #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && bit_in) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stoch_mmult_sequencer.sv
// Run controller for the stochastic matrix multiplier: local reset, SNG enable,
// pipeline flush, windowed ones-counting and latching of the binary estimates.
module stoch_mmult_sequencer
    import stoch_mmult_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ROWS     = 2,
    parameter int unsigned NUM_COLS     = 2,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                                        CLK,
    input  logic                                        nRST,
    input  logic                                        start,
    input  logic [CNT_WIDTH-1:0]                        win_len,
    input  logic [NUM_ROWS*NUM_COLS-1:0]                Y,
    output logic                                        mm_nrst,
    output logic                                        gen_en,
    output logic                                        busy,
    output logic                                        done,
    output logic [NUM_ROWS*NUM_COLS*(CNT_WIDTH+1)-1:0]  counts
);

    localparam int unsigned NE         = NUM_ROWS * NUM_COLS;
    localparam int unsigned CW         = count_width(CNT_WIDTH);
    localparam int unsigned FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned TW         = (FW > CW) ? FW : CW;
    localparam int unsigned FLUSH_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    seq_state_e           state_q, state_d;
    logic [TW-1:0]        ctr_q, ctr_d;
    logic [CW-1:0]        len_q, len_d;
    logic [CW-1:0]        len_m1;
    logic                 mm_nrst_q;
    logic [NE*CW-1:0]     counts_q;
    logic [CW-1:0]        acc [NE];
    logic                 acc_clr;
    logic                 acc_en;
    logic                 load_counts;
    logic                 run_last;
    logic                 flush_last;

    assign len_m1     = len_q - CW'(1);
    assign run_last   = (ctr_q == TW'(len_m1));
    assign flush_last = (ctr_q == TW'(FLUSH_LAST));

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        len_d       = len_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        load_counts = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero length field encodes the full 2^CNT_WIDTH window.
                    len_d   = (win_len == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, win_len};
                    state_d = StClear;
                end
            end
            StClear: begin
                acc_clr = 1'b1;
                ctr_d   = '0;
                state_d = (FLUSH_CYCLES == 0) ? StRun : StFlush;
            end
            StFlush: begin
                if (flush_last) begin
                    ctr_d   = '0;
                    state_d = StRun;
                end else begin
                    ctr_d = ctr_q + TW'(1);
                end
            end
            StRun: begin
                acc_en = 1'b1;
                if (run_last) begin
                    load_counts = 1'b1;
                    state_d     = StDone;
                end else begin
                    ctr_d = ctr_q + TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            ctr_q     <= '0;
            len_q     <= '0;
            mm_nrst_q <= 1'b0;
            counts_q  <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            len_q     <= len_d;
            mm_nrst_q <= (state_d != StClear);
            // Fold in the final RUN sample so counts are valid during DONE itself.
            if (load_counts) begin
                for (int k = 0; k < NE; k++) begin
                    counts_q[k*CW +: CW] <= acc[k] + CW'(Y[k]);
                end
            end
        end
    end

    for (genvar g = 0; g < NE; g++) begin : g_cnt
        stoch_ones_counter #(
            .WIDTH (CW)
        ) u_cnt (
            .CLK    (CLK),
            .nRST   (nRST),
            .clr    (acc_clr),
            .en     (acc_en),
            .bit_in (Y[g]),
            .count  (acc[g])
        );
    end

    assign mm_nrst = mm_nrst_q;
    assign gen_en  = (state_q == StFlush) || (state_q == StRun);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign counts  = counts_q;

endmodule

// File: tb/tb_stoch_mmult_sequencer.sv
// Self-checking bench: table of runs plus random runs against a window-sum model,
// with hand-written reset corner cases.
module tb_stoch_mmult_sequencer;

    localparam int unsigned NR = 2;
    localparam int unsigned NC = 2;
    localparam int unsigned NE = NR * NC;
    localparam int unsigned CWD = 4;
    localparam int unsigned F  = 1;
    localparam int unsigned CW = CWD + 1;

    localparam int ModeOnes   = 0;
    localparam int ModeToggle = 1;
    localparam int ModeRand   = 2;
    localparam int ModeZero   = 3;

    logic              CLK;
    logic              nRST;
    logic              start;
    logic [CWD-1:0]    win_len;
    logic [NE-1:0]     Y;
    logic              mm_nrst;
    logic              gen_en;
    logic              busy;
    logic              done;
    logic [NE*CW-1:0]  counts;

    int n_checks;
    int n_fail;
    logic [NE*CW-1:0] prev_counts;

    stoch_mmult_sequencer #(
        .NUM_ROWS     (NR),
        .NUM_COLS     (NC),
        .CNT_WIDTH    (CWD),
        .FLUSH_CYCLES (F)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .start   (start),
        .win_len (win_len),
        .Y       (Y),
        .mm_nrst (mm_nrst),
        .gen_en  (gen_en),
        .busy    (busy),
        .done    (done),
        .counts  (counts)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [CWD-1:0]   wl;
        int               mode;
        bit               hold;
        int               exp_done;
        bit               check_counts;
        logic [NE*CW-1:0] exp_counts;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NE-1:0] ygen(input int mode, input int rel);
        logic [NE-1:0] v;
        case (mode)
            ModeOnes:   v = '1;
            ModeToggle: begin
                v = '0;
                if (rel < 2 + int'(F)) v[0] = 1'b1;
                else v[0] = ((rel - (2 + int'(F))) % 2 == 0);
            end
            ModeRand:   v = NE'($urandom);
            default:    v = '0;
        endcase
        return v;
    endfunction

    // Starts a run from an IDLE cycle and checks every cycle up to the following IDLE cycle.
    // A run of length L occupies rel 1 (CLEAR) .. D=2+F+L (DONE); RUN is rel 2+F .. D-1.
    task automatic do_run(input logic [CWD-1:0] wl, input int mode, input bit hold,
                          output int done_rel, output logic [NE*CW-1:0] got_counts);
        int L;
        int D;
        int exp_cnt [NE];
        logic [NE*CW-1:0] exp_vec;
        L = (wl == 0) ? (1 << CWD) : int'(wl);
        D = 2 + int'(F) + L;
        done_rel   = 0;
        got_counts = '0;
        for (int k = 0; k < int'(NE); k++) exp_cnt[k] = 0;
        start   = 1'b1;
        win_len = wl;
        Y       = ygen(mode, 0);
        for (int rel = 1; rel <= D + 1; rel++) begin
            @(negedge CLK);
            chk("mm_nrst", 32'(mm_nrst), 32'(rel != 1));
            chk("gen_en", 32'(gen_en), 32'(rel >= 2 && rel <= D - 1));
            chk("busy", 32'(busy), 32'(rel <= D));
            chk("done", 32'(done), 32'(rel == D));
            if (done && done_rel == 0) done_rel = rel;
            if (rel == D) begin
                exp_vec = '0;
                for (int k = 0; k < int'(NE); k++) exp_vec[k*CW +: CW] = CW'(exp_cnt[k]);
                chk("counts_model", 32'(counts), 32'(exp_vec));
                got_counts  = counts;
                prev_counts = exp_vec;
            end else begin
                chk("counts_hold", 32'(counts), 32'(prev_counts));
            end
            if (rel <= D) begin
                start = hold;
                if (hold) win_len = CWD'($urandom);
            end else begin
                start = 1'b0;
            end
            Y = ygen(mode, rel);
            if (rel >= 2 + int'(F) && rel <= D - 1) begin
                for (int k = 0; k < int'(NE); k++) exp_cnt[k] += int'(Y[k]);
            end
        end
    endtask

    vec_t vecs [9];
    int dr;
    logic [NE*CW-1:0] gc;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        prev_counts = '0;
        start       = 1'b0;
        win_len     = '0;
        Y           = '0;
        nRST        = 1'b1;

        vecs[0] = '{4'd10, ModeOnes,   1'b0, 13, 1'b1, {5'd10, 5'd10, 5'd10, 5'd10}};
        vecs[1] = '{4'd0,  ModeToggle, 1'b0, 19, 1'b1, {5'd0, 5'd0, 5'd0, 5'd8}};
        vecs[2] = '{4'd7,  ModeOnes,   1'b1, 10, 1'b1, {5'd7, 5'd7, 5'd7, 5'd7}};
        vecs[3] = '{4'd3,  ModeOnes,   1'b1, 6,  1'b1, {5'd3, 5'd3, 5'd3, 5'd3}};
        vecs[4] = '{4'd5,  ModeOnes,   1'b1, 8,  1'b1, {5'd5, 5'd5, 5'd5, 5'd5}};
        vecs[5] = '{4'd9,  ModeRand,   1'b0, 12, 1'b0, '0};
        vecs[6] = '{4'd15, ModeRand,   1'b1, 18, 1'b0, '0};
        vecs[7] = '{4'd1,  ModeRand,   1'b0, 4,  1'b0, '0};
        vecs[8] = '{4'd2,  ModeZero,   1'b0, 5,  1'b1, '0};

        #2 nRST = 1'b0;
        #1;
        chk("rst_mm_nrst", 32'(mm_nrst), 32'd0);
        chk("rst_gen_en", 32'(gen_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_counts", 32'(counts), 32'd0);
        repeat (2) @(negedge CLK);
        chk("rst_hold_mm_nrst", 32'(mm_nrst), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("rel_mm_nrst", 32'(mm_nrst), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_run(vecs[i].wl, vecs[i].mode, vecs[i].hold, dr, gc);
            chk($sformatf("vec%0d_done_cycle", i), 32'(dr), 32'(vecs[i].exp_done));
            if (vecs[i].check_counts) chk($sformatf("vec%0d_counts", i), 32'(gc), 32'(vecs[i].exp_counts));
        end

        for (int i = 0; i < 6; i++) begin
            logic [CWD-1:0] wl;
            wl = CWD'($urandom);
            do_run(wl, ModeRand, 1'($urandom), dr, gc);
            chk("rand_done_cycle", 32'(dr), 32'(2 + int'(F) + ((wl == 0) ? 16 : int'(wl))));
        end

        // Reset in the middle of RUN: everything drops at once and no done follows.
        start   = 1'b1;
        win_len = 4'd8;
        Y       = '1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk("pre_rst_done", 32'(done), 32'd0);
        end
        chk("pre_rst_gen_en", 32'(gen_en), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_gen_en", 32'(gen_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_counts", 32'(counts), 32'd0);
        chk("mid_rst_mm_nrst", 32'(mm_nrst), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge CLK);
        chk("mid_rst_done2", 32'(done), 32'd0);
        nRST = 1'b1;
        prev_counts = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_mm_nrst", 32'(mm_nrst), 32'd1);
        end

        do_run(4'd6, ModeOnes, 1'b0, dr, gc);
        chk("post_rst_run_done_cycle", 32'(dr), 32'd9);
        chk("post_rst_run_counts", 32'(gc), 32'({5'd6, 5'd6, 5'd6, 5'd6}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stoch_mmult_sequencer.md
Name: stoch_mmult_sequencer

Overview:
Run controller for the stochastic matrix multiplier array. On each start request it:
- pulses a local reset into the multiplier,
- enables the operand bitstream generators,
- discards the pipeline-fill cycles,
- counts ones on every product bitstream over a programmable window,
- latches the per-element counts as the binary estimate and signals done.

It sits between the host/config logic and the multiplier plus its SNG front end.

Parameters:
NUM_ROWS, 2, rows of the product matrix
NUM_COLS, 2, columns of the product matrix
CNT_WIDTH, 8, window-length field width; maximum window is 2^CNT_WIDTH cycles
FLUSH_CYCLES, 1, multiplier output latency in cycles; outputs during flush are ignored (0 is legal)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
start  in  1  run request; sampled only in IDLE
win_len  in  CNT_WIDTH  window length, captured at accepted start; 0 means 2^CNT_WIDTH
Y  in  NUM_ROWS*NUM_COLS  product bitstreams from the multiplier, row-major
mm_nrst  out  1  registered active-low local reset to the multiplier and SNGs
gen_en  out  1  bitstream generator enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; counts are valid from this cycle
counts  out  NUM_ROWS*NUM_COLS*(CNT_WIDTH+1)  latched ones-counts, row-major; element k at [k*(CNT_WIDTH+1) +: CNT_WIDTH+1]

Behaviour:
- Clock and reset: one clock CLK. nRST is asynchronous and active-low.
- Values while nRST is low: state=IDLE, mm_nrst=0, gen_en=0, busy=0, done=0, counts=0, accumulators=0, window counter=0.
- First edge after nRST release: mm_nrst goes to 1.

FSM states:
- IDLE: mm_nrst=1, gen_en=0. If start=1, capture win_len (0 becomes 2^CNT_WIDTH) and go to CLEAR.
- CLEAR, 1 cycle: mm_nrst=0, gen_en=0, accumulators cleared. Go to FLUSH; if FLUSH_CYCLES=0, go to RUN.
- FLUSH, FLUSH_CYCLES cycles: gen_en=1. Y is ignored. Then go to RUN.
- RUN, exactly L cycles (L = captured length): gen_en=1. Each cycle, acc[k] += Y[k]. When the window counter reaches L-1, go to DONE.
- DONE, 1 cycle: gen_en=0, done=1, busy=1. counts register loaded with the final accumulator values, including the last RUN sample. Then go to IDLE.

Timing and latency:
- Accepted start at edge t gives CLEAR at t+1.
- done is asserted at t+2+FLUSH_CYCLES+L.

Width rules:
- Accumulators and counts are CNT_WIDTH+1 bits. The maximum value is 2^CNT_WIDTH, so no overflow and no saturation is needed.

Boundary conditions:
- start outside IDLE (including in DONE): ignored, not queued.
- win_len changing after capture: no effect on the current run.
- start held high continuously: exactly one IDLE cycle between runs.
- counts holds its last value until the next DONE. It is not cleared by CLEAR.
- nRST asserted mid-run: immediate return to reset values. The partial counts are lost and no done is issued.

Decomposition:
- Shared constants header (stoch_seq_defs): state encodings IDLE/CLEAR/FLUSH/RUN/DONE, and the count-width helper CNT_WIDTH+1.
- Sub-module stoch_ones_counter: one per element, generate loop over NUM_ROWS*NUM_COLS.
  - Ports: CLK, nRST, clr, en, bit_in, count.
  - Synchronous clr has priority over en.
- The sequencer owns the FSM, the window/flush counter and the counts latch.

Test Plan:
1. Reset: nRST low mid-simulation → all outputs 0 immediately. mm_nrst=1 on the first edge after release; busy stays 0.
2. NUM_ROWS=NUM_COLS=2, CNT_WIDTH=4, FLUSH_CYCLES=1; Y=4'b1111, start with win_len=10 →
   - mm_nrst low 1 cycle at t+1; gen_en high t+2..t+12;
   - done at t+13; counts = {10,10,10,10}.
3. Same config; win_len=0, Y[0] toggles 1,0,… from the first RUN cycle, Y[3:1]=0 →
   - done at t+19; count0=8, others 0;
   - Y[0]=1 during the FLUSH cycle is not counted.
4. start re-pulsed and win_len changed during RUN → no restart, done timing unchanged, counts match the original window.
5. start held high for two runs: win_len=3, then win_len=5 with Y=all ones →
   - first done gives counts=3; second done gives counts=5;
   - counts hold 3 between the two dones; one IDLE cycle between runs.
6. nRST pulsed low during RUN → gen_en=0, busy=0 and counts=0 at once; no done pulse. A following run completes normally.
